memory_loader_ram: RTL and testbench
====================================

MEMORY_LOADER_RAM -- requirements
Module: memory_loader_ram

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port `ram_addr`, input, 8 bits: CPU byte address.
REQ-004 SHALL have port `ram_data`, input, 8 bits: CPU write data.
REQ-005 SHALL have port `ram_we`, input, 1 bit: CPU write enable.
REQ-006 SHALL have port `ram_out`, output, 8 bits: read data returned to the CPU.
REQ-007 SHALL have port `load_valid`, input, 1 bit: loader byte valid.
REQ-008 SHALL have port `load_data`, input, 8 bits: loader byte.
REQ-009 SHALL have port `load_last`, input, 1 bit: marks the final loader byte; qualified by `load_valid`.
REQ-010 SHALL have port `load_ready`, output, 1 bit: block accepts loader bytes.
REQ-011 SHALL have port `cpu_run`, output, 1 bit: program loaded, CPU may execute.
REQ-012 SHALL have port `load_count`, output, 9 bits: number of bytes accepted since reset (0..256).
REQ-013 SHALL have port `io_out`, output, 8 bits: memory-mapped output register.
REQ-014 SHALL have port `io_strobe`, output, 1 bit: one-cycle pulse on each `io_out` update.

Function
REQ-015 SHALL hold 256 x 8-bit storage; storage contents are not cleared by reset.
REQ-016 SHALL implement a two-state FSM: LOAD (`load_ready`=1, `cpu_run`=0) and RUN (`load_ready`=0, `cpu_run`=1).
REQ-017 In LOAD, on each edge with `load_valid`=1, SHALL write `load_data` to mem[ptr], increment the 8-bit `ptr`, and increment `load_count`.
REQ-018 In LOAD, SHALL go to RUN on the edge that accepts a byte with `load_last`=1, or that accepts the 256th byte (`ptr` wraps 255->0); both together give a single transition.
REQ-019 In LOAD, `load_valid`=0 SHALL leave `ptr`, `load_count` and storage unchanged.
REQ-020 In LOAD, SHALL ignore `ram_we`; no CPU write reaches storage or `io_out`.
REQ-021 RUN SHALL be absorbing until reset; `load_valid` in RUN is ignored and `load_count` is frozen.
REQ-022 `ram_out` SHALL be a combinational read of mem[`ram_addr`] in both states: zero latency, valid in the same cycle, so the CPU's data register can latch it on the next edge.
REQ-023 In RUN, `ram_we`=1 SHALL write `ram_data` to mem[`ram_addr`] on the edge; the new value is visible on `ram_out` from the following cycle (no write-through).
REQ-024 Reading and writing the same address in one cycle SHALL return the old data on `ram_out` during that cycle.

Reset
REQ-025 `rst_n`=0 at an edge SHALL give: state=LOAD, `ptr`=0, `load_count`=0, `io_out`=8'h00, `io_strobe`=0, `cpu_run`=0, `load_ready`=1 from the next cycle.
REQ-026 Reset asserted mid-load or mid-run SHALL abort the operation with no write on that edge, and storage SHALL keep its prior contents.

Configuration
REQ-027 Macro `MEM_IO_EN` defined: address 8'hFF SHALL be the I/O port. A RUN write to 8'hFF updates `io_out` to `ram_data`, pulses `io_strobe` for exactly one cycle, and does not write mem[255]. A read of 8'hFF returns `io_out`. Loader writes to address 255 still go to mem[255].
REQ-028 `MEM_IO_EN` undefined: 8'hFF SHALL be ordinary RAM, `io_out` is held at 8'h00, and `io_strobe` is held at 0.

Verification
REQ-029 Reset, then stream 3 bytes AA,BB,CC with `load_last` on CC -> `load_count`=3 and `cpu_run`=1 the cycle after CC; `ram_addr`=01 -> `ram_out`=BB.
REQ-030 Stream 256 bytes (value = index) with no `load_last` -> RUN after byte 255, `load_count`=256, mem[0]=00, mem[200]=C8.
REQ-031 Gap stimulus: in LOAD, drop `load_valid` for 5 cycles between bytes -> `ptr`/`load_count` unchanged during the gap; also `ram_we`=1 addr 00 data 55 -> mem[00] unchanged.
REQ-032 In RUN, write 3C to addr 10 while reading addr 10 -> `ram_out`=old value that cycle, 3C next cycle; `load_valid` in RUN -> no effect.
REQ-033 With `MEM_IO_EN`: RUN write 7E to FF -> `io_out`=7E, `io_strobe` high one cycle, mem[255] unchanged. Without `MEM_IO_EN`: same write -> mem[255]=7E, `io_out`=00.
REQ-034 Assert `rst_n`=0 during RUN and during a load stream -> returns to LOAD with `load_count`=0, `io_out`=00, previously loaded bytes still readable.

Source files
------------

// File: rtl/memory_loader_ram.sv
// 256x8 program RAM with a byte-stream loader that hands over to the CPU.
// Optional I/O port at 8'hFF when MEM_IO_EN is defined.
module memory_loader_ram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ram_addr,
    input  logic [7:0] ram_data,
    input  logic       ram_we,
    output logic [7:0] ram_out,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_run,
    output logic [8:0] load_count,
    output logic [7:0] io_out,
    output logic       io_strobe
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] mem_q [256];
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       io_hit;

`ifdef MEM_IO_EN
    logic [7:0] io_q, io_d;
    logic       strobe_q, strobe_d;

    assign io_hit = (ram_addr == 8'hFF);
`else
    assign io_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = load_data;
`ifdef MEM_IO_EN
        io_d      = io_q;
        strobe_d  = 1'b0;
`endif
        case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 8'd1;
                    cnt_d  = cnt_q + 9'd1;
                    // a wrapping pointer means the whole array is filled
                    if (load_last || (ptr_q == 8'hFF)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ram_we) begin
                    if (io_hit) begin
`ifdef MEM_IO_EN
                        io_d     = ram_data;
                        strobe_d = 1'b1;
`endif
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = ram_addr;
                        mem_wdata = ram_data;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            ptr_q    <= 8'd0;
            cnt_q    <= 9'd0;
`ifdef MEM_IO_EN
            io_q     <= 8'h00;
            strobe_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
`ifdef MEM_IO_EN
            io_q     <= io_d;
            strobe_q <= strobe_d;
`endif
        end
    end

    // storage survives reset; only the write is suppressed
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign load_ready = (state_q == S_LOAD);
    assign cpu_run    = (state_q == S_RUN);
    assign load_count = cnt_q;

`ifdef MEM_IO_EN
    assign ram_out   = io_hit ? io_q : mem_q[ram_addr];
    assign io_out    = io_q;
    assign io_strobe = strobe_q;
`else
    assign ram_out   = mem_q[ram_addr];
    assign io_out    = 8'h00;
    assign io_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_memory_loader_ram.sv
// Scoreboard bench for memory_loader_ram: directed scenarios plus random
// traffic checked against a behavioural model of the loader and RAM.
module tb_memory_loader_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_out;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_run;
    logic [8:0] load_count;
    logic [7:0] io_out;
    logic       io_strobe;

    always #5 clk = ~clk;

`ifdef MEM_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    memory_loader_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_out    (ram_out),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .io_out     (io_out),
        .io_strobe  (io_strobe)
    );

    typedef struct {
        int         cyc;
        logic [7:0] ro;
        bit         ro_chk;
        bit         lr;
        bit         cr;
        logic [8:0] cnt;
        logic [7:0] io;
        bit         st;
    } exp_t;

    exp_t q[$];

    // behavioural model
    logic [7:0] m_mem [256];
    bit         m_known [256];
    bit         m_run;
    logic [7:0] m_ptr;
    int         m_cnt;
    logic [7:0] m_io;
    bit         m_st;
    bit         m_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [8:0] act,
                       input logic [8:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                chk("stale_expectation", 9'(cyc), 9'(e.cyc));
            end else begin
                if (e.ro_chk) chk("ram_out", {1'b0, ram_out}, {1'b0, e.ro});
                chk("load_ready", {8'd0, load_ready}, {8'd0, e.lr});
                chk("cpu_run", {8'd0, cpu_run}, {8'd0, e.cr});
                chk("load_count", load_count, e.cnt);
                chk("io_out", {1'b0, io_out}, {1'b0, e.io});
                chk("io_strobe", {8'd0, io_strobe}, {8'd0, e.st});
            end
        end
    end

    task automatic step(input bit r, input bit lv, input logic [7:0] ld,
                        input bit ll, input bit we, input logic [7:0] a,
                        input logic [7:0] d);
        exp_t e;
        rst_n      = r;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        ram_we     = we;
        ram_addr   = a;
        ram_data   = d;
        if (m_valid) begin
            e.cyc = cyc;
            if (IO_EN && a == 8'hFF) begin
                e.ro     = m_io;
                e.ro_chk = 1'b1;
            end else begin
                e.ro     = m_mem[a];
                e.ro_chk = m_known[a];
            end
            e.lr  = !m_run;
            e.cr  = m_run;
            e.cnt = 9'(m_cnt);
            e.io  = m_io;
            e.st  = m_st;
            q.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            m_run = 1'b0;
            m_ptr = 8'd0;
            m_cnt = 0;
            m_io  = 8'h00;
            m_st  = 1'b0;
        end else begin
            m_st = 1'b0;
            if (!m_run) begin
                if (lv) begin
                    m_mem[m_ptr]   = ld;
                    m_known[m_ptr] = 1'b1;
                    m_ptr          = m_ptr + 8'd1;
                    m_cnt          = m_cnt + 1;
                    if (ll || m_cnt == 256) m_run = 1'b1;
                end
            end else if (we) begin
                if (IO_EN && a == 8'hFF) begin
                    m_io = d;
                    m_st = 1'b1;
                end else begin
                    m_mem[a]   = d;
                    m_known[a] = 1'b1;
                end
            end
        end
        m_valid = 1'b1;
        #1;
    endtask

    task automatic idle(input logic [7:0] a);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, a, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        m_run = 1'b0; m_ptr = 8'd0; m_cnt = 0; m_io = 8'h00; m_st = 1'b0;
        #2;
        do_reset();
        do_reset();
        idle(8'h00);

        // three-byte program ended by load_last
        step(1, 1, 8'hAA, 0, 0, 8'h00, 8'h00);
        step(1, 1, 8'hBB, 0, 0, 8'h01, 8'h00);
        step(1, 1, 8'hCC, 1, 0, 8'h02, 8'h00);
        idle(8'h01);
        idle(8'h02);

        // gap in the stream with CPU writes that must be ignored
        do_reset();
        step(1, 1, 8'h11, 0, 0, 8'h00, 8'h00);
        step(1, 1, 8'h22, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h99, 1, 1, 8'h00, 8'h55);
        step(1, 1, 8'h33, 1, 0, 8'h00, 8'h00);
        idle(8'h00);
        idle(8'h02);

        // full 256-byte stream with no load_last
        do_reset();
        for (int i = 0; i < 256; i++) step(1, 1, 8'(i), 0, 0, 8'(i), 8'h00);
        idle(8'h00);
        idle(8'd200);
        idle(8'hFE);
        step(1, 1, 8'h77, 1, 0, 8'h05, 8'h00);
        idle(8'h05);

        // read-during-write returns old data
        step(1, 0, 8'h00, 0, 1, 8'h10, 8'h3C);
        idle(8'h10);
        step(1, 1, 8'hEE, 1, 0, 8'h10, 8'h00);
        idle(8'h00);

        // write to the I/O address
        step(1, 0, 8'h00, 0, 1, 8'hFF, 8'h7E);
        idle(8'hFF);
        idle(8'hFF);

        // reset during run, then during a load stream
        do_reset();
        idle(8'd200);
        step(1, 1, 8'h01, 0, 0, 8'd201, 8'h00);
        step(1, 1, 8'h02, 0, 0, 8'd202, 8'h00);
        step(0, 1, 8'h03, 0, 0, 8'd2, 8'h00);
        idle(8'd2);
        idle(8'd150);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit         r, lv, ll, we;
            logic [7:0] a;
            r  = ($urandom_range(0, 99) != 0);
            lv = ($urandom_range(0, 3) != 0);
            ll = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       a = 8'hFF;
                1:       a = 8'(m_ptr);
                default: a = 8'($urandom);
            endcase
            step(r, lv, 8'($urandom), ll, we, a, 8'($urandom));
        end

        idle(8'h00);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) chk("queue_drained", 9'(q.size()), 9'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
